// File: rtl/rca_operand_sequencer.sv
// ---------------------------------------------------------------------------
// rca_operand_sequencer
//
// Front-end and capture stage for an external 16-bit ripple-carry adder.
// Five bytes arriving on a valid/ready stream are assembled into operand A,
// operand B and a carry-in, which drive the adder directly. After a fixed
// settle interval the adder's {cout,sum} is latched and offered on a
// valid/ready result port. Only one transaction is in flight at a time.
//
// Parameters:
//   SETTLE_CYCLES  cycles from the last operand byte to result capture (1..15)
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   rst           synchronous active-low reset
//   byte_in       operand byte stream
//   byte_valid    byte_in holds a valid byte
//   byte_ready    block accepts a byte this cycle (high only in LOAD)
//   op_a          operand A to the adder
//   op_b          operand B to the adder
//   op_cin        carry-in to the adder
//   add_sum       adder sum
//   add_cout      adder carry-out
//   res_data      captured {cout,sum}
//   res_valid     res_data is valid
//   res_ready     downstream accepts the result
//   busy          high while settling or presenting a result
//   result_count  number of completed result handshakes, wraps 255->0
// ---------------------------------------------------------------------------
module rca_operand_sequencer #(
   parameter int SETTLE_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic        op_cin,
   input  logic [15:0] add_sum,
   input  logic        add_cout,
   output logic [16:0] res_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        busy,
   output logic [7:0]  result_count
);

   typedef enum logic [1:0] {
      LOAD,
      SETTLE,
      OUTPUT
   } state_t;

   // Terminal count of the settle counter; the capture happens on the edge
   // where the counter holds this value, which places res_valid exactly
   // SETTLE_CYCLES edges after the last byte is accepted.
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [2:0] LAST_BYTE   = 3'd4;

   state_t      state;
   state_t      state_next;
   logic [2:0]  byte_idx;
   logic [3:0]  settle_cnt;

   logic        byte_fire;
   logic        last_byte_fire;
   logic        settle_done;
   logic        res_fire;

   // Handshake qualifiers. All of them are gated by state so that a valid or
   // ready seen in the wrong phase has no effect at all.
   assign byte_fire      = (state == LOAD) && byte_valid;
   assign last_byte_fire = byte_fire && (byte_idx == LAST_BYTE);
   assign settle_done    = (state == SETTLE) && (settle_cnt == SETTLE_LAST);
   assign res_fire       = (state == OUTPUT) && res_ready;

   // State register. Reset returns to LOAD so byte_ready is high in the
   // first cycle after reset is released.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and phase outputs. LOAD accepts bytes, SETTLE waits for the
   // adder's ripple to complete, OUTPUT holds the result until it is taken.
   always_comb begin
      state_next = state;
      byte_ready = 1'b0;
      busy       = 1'b0;
      case (state)
         LOAD: begin
            byte_ready = 1'b1;
            if (last_byte_fire) begin
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            busy = 1'b1;
            if (settle_done) begin
               state_next = OUTPUT;
            end
         end
         OUTPUT: begin
            busy = 1'b1;
            if (res_fire) begin
               state_next = LOAD;
            end
         end
         default: begin
            state_next = LOAD;
         end
      endcase
   end

   // Byte index. It advances only on an accepted byte, so stall cycles in
   // LOAD hold the position, and it wraps back to zero after the carry-in
   // byte so the next transaction starts with operand A.
   always_ff @(posedge clk) begin
      if (!rst) begin
         byte_idx <= 3'd0;
      end else if (last_byte_fire) begin
         byte_idx <= 3'd0;
      end else if (byte_fire) begin
         byte_idx <= byte_idx + 3'd1;
      end
   end

   // Operand assembly. Each register changes only on the edge its byte is
   // accepted; outside LOAD byte_fire is low, so the adder inputs stay stable
   // through SETTLE and OUTPUT. Only bit 0 of the fifth byte is meaningful.
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_a   <= 16'h0000;
         op_b   <= 16'h0000;
         op_cin <= 1'b0;
      end else if (byte_fire) begin
         case (byte_idx)
            3'd0:    op_a[7:0]  <= byte_in;
            3'd1:    op_a[15:8] <= byte_in;
            3'd2:    op_b[7:0]  <= byte_in;
            3'd3:    op_b[15:8] <= byte_in;
            3'd4:    op_cin     <= byte_in[0];
            default: op_cin     <= op_cin;
         endcase
      end
   end

   // Settle counter. Cleared when the last byte is accepted and counting
   // every cycle spent in SETTLE; its value elsewhere is irrelevant.
   always_ff @(posedge clk) begin
      if (!rst) begin
         settle_cnt <= 4'd0;
      end else if (last_byte_fire) begin
         settle_cnt <= 4'd0;
      end else if (state == SETTLE) begin
         settle_cnt <= settle_cnt + 4'd1;
      end
   end

   // Result capture and hand-off. res_data is the raw adder output sampled
   // once at the end of the settle window and held until the next capture,
   // so it stays stable for as long as downstream stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         res_data  <= 17'h00000;
         res_valid <= 1'b0;
      end else if (settle_done) begin
         res_data  <= {add_cout, add_sum};
         res_valid <= 1'b1;
      end else if (res_fire) begin
         res_valid <= 1'b0;
      end
   end

   // Completed-transaction counter; natural 8-bit wrap from 255 to 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         result_count <= 8'd0;
      end else if (res_fire) begin
         result_count <= result_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_rca_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rca_operand_sequencer
//
// Directed bench for rca_operand_sequencer. A behavioural adder closes the
// loop from op_a/op_b/op_cin back to add_sum/add_cout; expected results are
// hand-computed constants or computed in the bench from the applied bytes.
// ---------------------------------------------------------------------------
module tb_rca_operand_sequencer;

   logic        clk;
   logic        rst;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        op_cin;
   logic [15:0] add_sum;
   logic        add_cout;
   logic [16:0] res_data;
   logic        res_valid;
   logic        res_ready;
   logic        busy;
   logic [7:0]  result_count;

   int errors;
   int checks;
   int latency;

   logic [15:0] vecA;
   logic [15:0] vecB;
   logic [7:0]  vecCin;
   logic [16:0] vecSum;

   rca_operand_sequencer #(.SETTLE_CYCLES(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .op_cin       (op_cin),
      .add_sum      (add_sum),
      .add_cout     (add_cout),
      .res_data     (res_data),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .busy         (busy),
      .result_count (result_count)
   );

   // Behavioural stand-in for the external ripple-carry adder.
   assign {add_cout, add_sum} = 17'(op_a) + 17'(op_b) + 17'(op_cin);

   // 100 MHz-style free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something upstream of the bounded waits misbehaves.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Offer one byte and hold it until accepted (bounded). With gap set, a
   // byte_valid=0 stall cycle follows the accepted byte.
   task automatic applyStimulus(input logic [7:0] b, input bit gap);
      int waitCycles;
      waitCycles = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && waitCycles < 100) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      if (!byte_ready) begin
         checkOutput("byte_accept_timeout", 32'(byte_ready), 32'd1);
      end else begin
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      if (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic loadOperands(input logic [15:0] a, input logic [15:0] b,
                               input logic [7:0] cinByte, input bit gap);
      applyStimulus(a[7:0], gap);
      applyStimulus(a[15:8], gap);
      applyStimulus(b[7:0], gap);
      applyStimulus(b[15:8], gap);
      applyStimulus(cinByte, 1'b0);
   endtask

   // Count edges from the current point until res_valid rises (bounded).
   task automatic waitResult(output int cycles);
      cycles = 0;
      while (!res_valid && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
      end
      if (!res_valid) begin
         checkOutput("result_timeout", 32'(res_valid), 32'd1);
      end
   endtask

   task automatic takeResult();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic pulseReset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      rst        = 1'b0;
      byte_in    = 8'h00;
      byte_valid = 1'b0;
      res_ready  = 1'b0;

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      checkOutput("rst_op_a", 32'(op_a), 32'h0);
      checkOutput("rst_op_b", 32'(op_b), 32'h0);
      checkOutput("rst_op_cin", 32'(op_cin), 32'h0);
      checkOutput("rst_res_data", 32'(res_data), 32'h0);
      checkOutput("rst_res_valid", 32'(res_valid), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      checkOutput("rst_count", 32'(result_count), 32'h0);
      checkOutput("rst_byte_ready", 32'(byte_ready), 32'h1);

      // Basic load, latency and hold under res_ready=0
      $display("[TB] basic load 1234 + 4321 + 1");
      loadOperands(16'h1234, 16'h4321, 8'h01, 1'b0);
      checkOutput("t1_op_a", 32'(op_a), 32'h1234);
      checkOutput("t1_op_b", 32'(op_b), 32'h4321);
      checkOutput("t1_op_cin", 32'(op_cin), 32'h1);
      checkOutput("t1_busy", 32'(busy), 32'h1);
      checkOutput("t1_ready_low", 32'(byte_ready), 32'h0);
      checkOutput("t1_valid_early", 32'(res_valid), 32'h0);
      waitResult(latency);
      checkOutput("t1_latency", 32'(latency), 32'd8);
      checkOutput("t1_res_data", 32'(res_data), 32'h05556);
      repeat (6) begin
         @(posedge clk); #1;
      end
      checkOutput("t1_hold_valid", 32'(res_valid), 32'h1);
      checkOutput("t1_hold_data", 32'(res_data), 32'h05556);
      checkOutput("t1_hold_count", 32'(result_count), 32'h0);
      takeResult();
      checkOutput("t1_valid_drop", 32'(res_valid), 32'h0);
      checkOutput("t1_count", 32'(result_count), 32'h1);
      checkOutput("t1_ready_back", 32'(byte_ready), 32'h1);
      checkOutput("t1_busy_drop", 32'(busy), 32'h0);

      // Carry-in uses bit 0 only; carry out of bit 15
      $display("[TB] FFFF + 0001, cin byte FE");
      loadOperands(16'hFFFF, 16'h0001, 8'hFE, 1'b0);
      checkOutput("t2_op_cin", 32'(op_cin), 32'h0);
      waitResult(latency);
      checkOutput("t2_latency", 32'(latency), 32'd8);
      checkOutput("t2_res_data", 32'(res_data), 32'h10000);
      takeResult();
      checkOutput("t2_count", 32'(result_count), 32'h2);

      // byte_valid toggling every cycle
      $display("[TB] FFFF + FFFF + 1 with stalls");
      loadOperands(16'hFFFF, 16'hFFFF, 8'h01, 1'b1);
      checkOutput("t3_op_a", 32'(op_a), 32'hFFFF);
      checkOutput("t3_op_b", 32'(op_b), 32'hFFFF);
      checkOutput("t3_op_cin", 32'(op_cin), 32'h1);
      waitResult(latency);
      checkOutput("t3_latency", 32'(latency), 32'd8);
      checkOutput("t3_res_data", 32'(res_data), 32'h1FFFF);
      takeResult();
      checkOutput("t3_count", 32'(result_count), 32'h3);

      // byte_valid held high through SETTLE and OUTPUT
      $display("[TB] bytes offered while busy");
      loadOperands(16'h1111, 16'h2222, 8'h00, 1'b0);
      byte_in    = 8'hAA;
      byte_valid = 1'b1;
      checkOutput("t4_ready_settle", 32'(byte_ready), 32'h0);
      waitResult(latency);
      checkOutput("t4_latency", 32'(latency), 32'd8);
      checkOutput("t4_ready_output", 32'(byte_ready), 32'h0);
      checkOutput("t4_op_a", 32'(op_a), 32'h1111);
      checkOutput("t4_op_b", 32'(op_b), 32'h2222);
      checkOutput("t4_op_cin", 32'(op_cin), 32'h0);
      checkOutput("t4_res_data", 32'(res_data), 32'h03333);
      takeResult();
      checkOutput("t4_count", 32'(result_count), 32'h4);
      checkOutput("t4_op_a_unconsumed", 32'(op_a), 32'h1111);
      checkOutput("t4_ready_after", 32'(byte_ready), 32'h1);
      @(posedge clk); #1;
      byte_valid = 1'b0;
      checkOutput("t4_first_byte", 32'(op_a), 32'h11AA);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h05, 1'b0);
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h00, 1'b0);
      checkOutput("t4b_op_a", 32'(op_a), 32'h00AA);
      checkOutput("t4b_op_b", 32'(op_b), 32'h0005);
      waitResult(latency);
      checkOutput("t4b_latency", 32'(latency), 32'd8);
      checkOutput("t4b_res_data", 32'(res_data), 32'h000AF);
      takeResult();
      checkOutput("t4b_count", 32'(result_count), 32'h5);

      // Reset in the middle of a load
      $display("[TB] reset after three bytes");
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      applyStimulus(8'h33, 1'b0);
      checkOutput("t5_partial_a", 32'(op_a), 32'h2211);
      pulseReset();
      checkOutput("t5_op_a", 32'(op_a), 32'h0);
      checkOutput("t5_op_b", 32'(op_b), 32'h0);
      checkOutput("t5_res_valid", 32'(res_valid), 32'h0);
      checkOutput("t5_count", 32'(result_count), 32'h0);
      checkOutput("t5_byte_ready", 32'(byte_ready), 32'h1);
      loadOperands(16'h0000, 16'h0000, 8'h00, 1'b0);
      waitResult(latency);
      checkOutput("t5_latency", 32'(latency), 32'd8);
      checkOutput("t5_res_data", 32'(res_data), 32'h0);
      takeResult();
      checkOutput("t5_count_after", 32'(result_count), 32'h1);

      // 256 back-to-back transactions with res_ready held high
      $display("[TB] 256 transactions, counter wrap");
      pulseReset();
      res_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         vecA   = 16'(i * 257) ^ 16'h5A5A;
         vecB   = 16'(i * 37 + 16'h0F0F);
         vecCin = 8'(i);
         vecSum = 17'(vecA) + 17'(vecB) + 17'(vecCin[0]);
         loadOperands(vecA, vecB, vecCin, 1'b0);
         waitResult(latency);
         checkOutput($sformatf("t6_res_%0d", i), 32'(res_data), 32'(vecSum));
         if (i == 255) begin
            checkOutput("t6_count_255", 32'(result_count), 32'd255);
         end
         @(posedge clk); #1;
      end
      res_ready = 1'b0;
      checkOutput("t6_count_wrap", 32'(result_count), 32'h0);
      checkOutput("t6_valid_idle", 32'(res_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
